// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit controller.
//   - lsu_state_e : controller FSM states (IDLE -> REQ -> DONE -> IDLE)
//   - LD_* / ST_* : encodings of i_ld_sel / i_st_sel
//   - LSU_TIMEOUT_DEF : default bus timeout in REQ cycles
//   - st_wdata_f / st_bmask_f : store lane replication and byte enables
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_e;

   localparam logic [2:0] LD_LB   = 3'd0;
   localparam logic [2:0] LD_LH   = 3'd1;
   localparam logic [2:0] LD_LW   = 3'd2;
   localparam logic [2:0] LD_LBU  = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;
   localparam logic [2:0] LD_NONE = 3'd5;

   localparam logic [1:0] ST_SB   = 2'd0;
   localparam logic [1:0] ST_SH   = 2'd1;
   localparam logic [1:0] ST_SW   = 2'd2;
   localparam logic [1:0] ST_NONE = 2'd3;

   localparam int unsigned LSU_TIMEOUT_DEF = 255;

   // Sub-word stores replicate the datum into every lane it could land in,
   // so the byte enables alone pick the destination.
   function automatic logic [31:0] st_wdata_f(input logic [1:0] sel, input logic [31:0] d);
      case (sel)
         ST_SB:   st_wdata_f = {4{d[7:0]}};
         ST_SH:   st_wdata_f = {2{d[15:0]}};
         default: st_wdata_f = d;
      endcase
   endfunction

   function automatic logic [3:0] st_bmask_f(input logic [1:0] sel, input logic [1:0] lane);
      case (sel)
         ST_SB:   st_bmask_f = 4'b0001 << lane;
         ST_SH:   st_bmask_f = lane[1] ? 4'b1100 : 4'b0011;
         default: st_bmask_f = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// lsu_ld_align: combinational load lane select and extension.
//   i_word   : word captured from the bus
//   i_lane   : byte offset of the access within the word
//   i_ld_sel : load type (LB/LH/LW/LBU/LHU; others give 0)
//   o_data   : extended load result
module lsu_ld_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [2:0]  i_ld_sel,
   output logic [31:0] o_data
);

   logic [31:0] shifted;

   // Halfword accesses are aligned (lane 0 or 2), so one shift by the lane
   // serves both byte and halfword extraction.
   assign shifted = i_word >> {i_lane, 3'b000};

   always_comb begin
      o_data = '0;
      case (i_ld_sel)
         LD_LB:   o_data = {{24{shifted[7]}}, shifted[7:0]};
         LD_LH:   o_data = {{16{shifted[15]}}, shifted[15:0]};
         LD_LW:   o_data = i_word;
         LD_LBU:  o_data = {24'd0, shifted[7:0]};
         LD_LHU:  o_data = {16'd0, shifted[15:0]};
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the core and a
// req/ack memory bus.
//   Core side : i_lsu_addr, i_st_data, i_ld_sel, i_st_sel, i_mem_wren in;
//               o_ld_data, o_stall, o_misaligned, o_bus_err out.
//   Bus side  : o_bus_req/we/addr/wdata/bmask out; i_bus_ack, i_bus_rdata in.
//   Debug     : o_dbg_state exposes the FSM state.
// Bus handshake: o_bus_req stays high with stable addr/we/wdata/bmask from
// the first REQ cycle until the cycle i_bus_ack is sampled high; an ack in
// any other state is ignored. A request with no ack for TIMEOUT cycles is
// abandoned with a one-cycle o_bus_err (coincident with DONE) and zero data.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic [2:0]  i_ld_sel,
   input  logic [1:0]  i_st_sel,
   input  logic        i_mem_wren,
   output logic [31:0] o_ld_data,
   output logic        o_stall,
   output logic        o_misaligned,
   output logic        o_bus_err,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_bmask,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   output logic [1:0]  o_dbg_state
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  bmask_q;
   logic        we_q;
   logic [2:0]  ld_sel_q;
   logic [1:0]  lane_q;

   logic        is_store, is_load, mis, latch_en;
   logic [31:0] align_data;

   assign is_store = i_mem_wren && (i_st_sel != ST_NONE);
   assign is_load  = !is_store && (i_ld_sel <= LD_LHU);

   always_comb begin
      mis = 1'b0;
      if (is_store)
         mis = ((i_st_sel == ST_SW) && (i_lsu_addr[1:0] != 2'b00)) ||
               ((i_st_sel == ST_SH) && i_lsu_addr[0]);
      else if (is_load)
         mis = ((i_ld_sel == LD_LW) && (i_lsu_addr[1:0] != 2'b00)) ||
               (((i_ld_sel == LD_LH) || (i_ld_sel == LD_LHU)) && i_lsu_addr[0]);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      err_d        = 1'b0;
      latch_en     = 1'b0;
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_store || is_load) begin
               if (mis) begin
                  o_misaligned = 1'b1;
               end else begin
                  o_stall  = 1'b1;
                  latch_en = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_REQ;
               end
            end
         end
         S_REQ: begin
            o_stall = 1'b1;
            if (i_bus_ack) begin
               rdata_d = i_bus_rdata;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            // Always retire; the core has advanced by the next cycle.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         bmask_q  <= '0;
         we_q     <= 1'b0;
         ld_sel_q <= '0;
         lane_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (latch_en) begin
            addr_q   <= {i_lsu_addr[31:2], 2'b00};
            wdata_q  <= is_store ? st_wdata_f(i_st_sel, i_st_data) : 32'd0;
            bmask_q  <= is_store ? st_bmask_f(i_st_sel, i_lsu_addr[1:0]) : 4'b1111;
            we_q     <= is_store;
            ld_sel_q <= i_ld_sel;
            lane_q   <= i_lsu_addr[1:0];
         end
      end
   end

   lsu_ld_align u_ld_align (
      .i_word   (rdata_q),
      .i_lane   (lane_q),
      .i_ld_sel (ld_sel_q),
      .o_data   (align_data)
   );

   assign o_bus_req   = (state_q == S_REQ);
   assign o_bus_we    = o_bus_req ? we_q    : 1'b0;
   assign o_bus_addr  = o_bus_req ? addr_q  : 32'd0;
   assign o_bus_wdata = o_bus_req ? wdata_q : 32'd0;
   assign o_bus_bmask = o_bus_req ? bmask_q : 4'd0;
   assign o_bus_err   = err_q;
   assign o_ld_data   = ((state_q == S_DONE) && !we_q) ? align_data : 32'd0;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_lsu_addr, i_st_data, i_bus_rdata;
  logic [2:0]  i_ld_sel;
  logic [1:0]  i_st_sel;
  logic        i_mem_wren, i_bus_ack;
  logic [31:0] o_ld_data, o_bus_addr, o_bus_wdata;
  logic        o_stall, o_misaligned, o_bus_err, o_bus_req, o_bus_we;
  logic [3:0]  o_bus_bmask;
  logic [1:0]  o_dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 i_clk = ~i_clk;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .i_ld_sel(i_ld_sel), .i_st_sel(i_st_sel), .i_mem_wren(i_mem_wren),
    .o_ld_data(o_ld_data), .o_stall(o_stall), .o_misaligned(o_misaligned),
    .o_bus_err(o_bus_err), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_bmask(o_bus_bmask),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_dbg_state(o_dbg_state)
  );

  // driver tasks
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle();
    i_lsu_addr = '0; i_st_data = '0; i_ld_sel = LD_NONE; i_st_sel = ST_NONE;
    i_mem_wren = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = '0;
  endtask

  // Presents one access in the current (IDLE) cycle, then idles the inputs and
  // acks on the ack_delay-th REQ cycle (never if ack_delay <= 0). Records what
  // the bus and core outputs showed. Bounded to 40 cycles.
  task automatic run_access(input logic st, input logic [2:0] lsel, input logic [1:0] ssel,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input int ack_delay, input logic [31:0] rdata,
                            output logic [31:0] ld_seen, output int stall_n, output int req_n,
                            output logic done_seen, output logic err_seen,
                            output logic [31:0] baddr, output logic [31:0] bwdata,
                            output logic [3:0] bmask, output logic bwe);
    ld_seen = '0; stall_n = 0; req_n = 0; done_seen = 1'b0; err_seen = 1'b0;
    baddr = '0; bwdata = '0; bmask = '0; bwe = 1'b0;
    i_mem_wren = st; i_ld_sel = lsel; i_st_sel = ssel; i_lsu_addr = addr; i_st_data = sdata;
    #1;
    if (o_stall) stall_n++;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      cyc();
      set_idle();
      #1;
      if (o_bus_req) begin
        req_n++;
        if (req_n == 1) begin
          baddr = o_bus_addr; bwdata = o_bus_wdata; bmask = o_bus_bmask; bwe = o_bus_we;
        end
        if (req_n == ack_delay) begin
          i_bus_ack = 1'b1; i_bus_rdata = rdata;
          #1;
        end
      end
      if (o_stall) stall_n++;
      if (o_dbg_state == 2'd2) begin
        done_seen = 1'b1; ld_seen = o_ld_data; err_seen = o_bus_err;
      end
    end
  endtask

  logic [31:0] ld, ba, bw;
  logic [3:0]  bm;
  logic        we, dn, er;
  int          sn, rn;

  task automatic test_reset();
    i_rst_n = 1'b0; set_idle();
    cyc(); cyc();
    tests_run++; if ({o_stall, o_bus_req, o_misaligned, o_bus_err} !== 4'b0) begin tests_failed++; $display("FAIL reset_ctrl got %b exp 0000", {o_stall, o_bus_req, o_misaligned, o_bus_err}); end
    tests_run++; if ({o_ld_data, o_bus_addr, o_bus_wdata} !== 96'd0) begin tests_failed++; $display("FAIL reset_data got %h %h %h exp 0", o_ld_data, o_bus_addr, o_bus_wdata); end
    tests_run++; if (o_dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", o_dbg_state); end
    i_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_lw_wait();
    run_access(1'b0, LD_LW, ST_NONE, 32'h100, 32'h0, 2, 32'hDEADBEEF, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (dn !== 1'b1) begin tests_failed++; $display("FAIL lw_done got %b exp 1", dn); end
    tests_run++; if (ld !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data got %h exp deadbeef", ld); end
    tests_run++; if (sn !== 3) begin tests_failed++; $display("FAIL lw_stall_cycles got %0d exp 3", sn); end
    tests_run++; if ({ba, bm, we} !== {32'h100, 4'b1111, 1'b0}) begin tests_failed++; $display("FAIL lw_bus got %h %b %b exp 00000100 1111 0", ba, bm, we); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL lw_err got %b exp 0", er); end
    cyc();
    tests_run++; if ({o_dbg_state, o_ld_data} !== {2'd0, 32'd0}) begin tests_failed++; $display("FAIL lw_after got %0d %h exp 0 0", o_dbg_state, o_ld_data); end
  endtask

  task automatic test_sub_loads();
    run_access(1'b0, LD_LB, ST_NONE, 32'h203, 32'h0, 1, 32'h80112233, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (ld !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_data got %h exp ffffff80", ld); end
    tests_run++; if ({ba, sn, rn} !== {32'h200, 32'd2, 32'd1}) begin tests_failed++; $display("FAIL lb_timing got %h %0d %0d exp 00000200 2 1", ba, sn, rn); end
    cyc();
    run_access(1'b0, LD_LBU, ST_NONE, 32'h203, 32'h0, 1, 32'h80112233, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (ld !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_data got %h exp 00000080", ld); end
    cyc();
    run_access(1'b0, LD_LH, ST_NONE, 32'h202, 32'h0, 1, 32'h80112233, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (ld !== 32'hFFFF8011) begin tests_failed++; $display("FAIL lh_data got %h exp ffff8011", ld); end
    cyc();
    run_access(1'b0, LD_LHU, ST_NONE, 32'h0, 32'h0, 1, 32'h1234F00D, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (ld !== 32'h0000F00D) begin tests_failed++; $display("FAIL lhu_data got %h exp 0000f00d", ld); end
    cyc();
    run_access(1'b0, LD_LB, ST_NONE, 32'h1, 32'h0, 1, 32'h00007F00, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if (ld !== 32'h0000007F) begin tests_failed++; $display("FAIL lb_pos_data got %h exp 0000007f", ld); end
    cyc();
  endtask

  task automatic test_stores();
    run_access(1'b1, LD_NONE, ST_SH, 32'h2, 32'h0000ABCD, 1, 32'hFFFFFFFF, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({ba, bw, bm, we} !== {32'h0, 32'hABCDABCD, 4'b1100, 1'b1}) begin tests_failed++; $display("FAIL sh_bus got %h %h %b %b exp 00000000 abcdabcd 1100 1", ba, bw, bm, we); end
    tests_run++; if (ld !== 32'd0) begin tests_failed++; $display("FAIL sh_ld_data got %h exp 0", ld); end
    cyc();
    run_access(1'b1, LD_NONE, ST_SB, 32'h11, 32'hCAFE005A, 1, 32'h0, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({ba, bw, bm, we} !== {32'h10, 32'h5A5A5A5A, 4'b0010, 1'b1}) begin tests_failed++; $display("FAIL sb_bus got %h %h %b %b exp 00000010 5a5a5a5a 0010 1", ba, bw, bm, we); end
    cyc();
    run_access(1'b1, LD_NONE, ST_SH, 32'h4, 32'h99991234, 1, 32'h0, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({ba, bw, bm} !== {32'h4, 32'h12341234, 4'b0011}) begin tests_failed++; $display("FAIL sh_lo_bus got %h %h %b exp 00000004 12341234 0011", ba, bw, bm); end
    cyc();
    // store wins over a simultaneous load
    run_access(1'b1, LD_LW, ST_SW, 32'h8, 32'h11223344, 1, 32'h55555555, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({ba, bw, bm, we} !== {32'h8, 32'h11223344, 4'b1111, 1'b1}) begin tests_failed++; $display("FAIL sw_prio_bus got %h %h %b %b exp 00000008 11223344 1111 1", ba, bw, bm, we); end
    tests_run++; if (ld !== 32'd0) begin tests_failed++; $display("FAIL sw_prio_ld got %h exp 0", ld); end
    cyc();
    // wren with ST_NONE is not a store; the load proceeds
    run_access(1'b1, LD_LW, ST_NONE, 32'h20, 32'h0, 1, 32'h0BADF00D, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({we, ld} !== {1'b0, 32'h0BADF00D}) begin tests_failed++; $display("FAIL st_none_load got %b %h exp 0 0badf00d", we, ld); end
    cyc();
  endtask

  task automatic test_misaligned();
    logic [2:0] ls [3] = '{LD_LW, LD_LH, LD_LHU};
    logic [31:0] ad [3] = '{32'h101, 32'h203, 32'h5};
    for (int i = 0; i < 3; i++) begin
      i_ld_sel = ls[i]; i_lsu_addr = ad[i]; i_mem_wren = 1'b0; i_st_sel = ST_NONE;
      #1;
      tests_run++; if ({o_misaligned, o_stall, o_bus_req, o_ld_data} !== {3'b100, 32'd0}) begin tests_failed++; $display("FAIL mis_ld%0d got %b%b%b %h exp 100 0", i, o_misaligned, o_stall, o_bus_req, o_ld_data); end
      cyc(); set_idle(); #1;
      tests_run++; if ({o_misaligned, o_bus_req, o_dbg_state} !== 4'b0000) begin tests_failed++; $display("FAIL mis_ld%0d_after got %b%b %0d exp 00 0", i, o_misaligned, o_bus_req, o_dbg_state); end
    end
    i_mem_wren = 1'b1; i_st_sel = ST_SW; i_lsu_addr = 32'h2;
    #1;
    tests_run++; if ({o_misaligned, o_stall} !== 2'b10) begin tests_failed++; $display("FAIL mis_sw got %b%b exp 10", o_misaligned, o_stall); end
    cyc();
    i_st_sel = ST_SH; i_lsu_addr = 32'h3;
    #1;
    tests_run++; if ({o_misaligned, o_stall} !== 2'b10) begin tests_failed++; $display("FAIL mis_sh got %b%b exp 10", o_misaligned, o_stall); end
    cyc(); set_idle();
    cyc();
    tests_run++; if ({o_bus_req, o_dbg_state} !== 3'b000) begin tests_failed++; $display("FAIL mis_st_after got %b %0d exp 0 0", o_bus_req, o_dbg_state); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, LD_LW, ST_NONE, 32'h40, 32'h0, 0, 32'h0, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({dn, er} !== 2'b11) begin tests_failed++; $display("FAIL to_done_err got %b%b exp 11", dn, er); end
    tests_run++; if (rn !== 4) begin tests_failed++; $display("FAIL to_req_cycles got %0d exp 4", rn); end
    tests_run++; if (ld !== 32'd0) begin tests_failed++; $display("FAIL to_data got %h exp 0", ld); end
    cyc();
    tests_run++; if ({o_bus_err, o_dbg_state} !== 3'b000) begin tests_failed++; $display("FAIL to_after got %b %0d exp 0 0", o_bus_err, o_dbg_state); end
  endtask

  task automatic test_stray_ack();
    set_idle(); i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
    cyc(); #1;
    tests_run++; if ({o_bus_req, o_stall, o_dbg_state, o_ld_data} !== 35'd0) begin tests_failed++; $display("FAIL stray_ack got %b%b %0d %h exp 00 0 0", o_bus_req, o_stall, o_dbg_state, o_ld_data); end
    set_idle();
    cyc();
  endtask

  task automatic test_reset_mid_req();
    i_ld_sel = LD_LW; i_lsu_addr = 32'h80;
    cyc(); set_idle(); #1;
    tests_run++; if (o_bus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_req1 got %b exp 1", o_bus_req); end
    cyc(); #1;
    tests_run++; if (o_bus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_req2 got %b exp 1", o_bus_req); end
    i_rst_n = 1'b0;
    cyc(); #1;
    tests_run++; if ({o_bus_req, o_stall, o_bus_err, o_dbg_state} !== 5'd0) begin tests_failed++; $display("FAIL rst_mid got %b%b%b %0d exp 000 0", o_bus_req, o_stall, o_bus_err, o_dbg_state); end
    i_rst_n = 1'b1;
    cyc(); cyc();
    tests_run++; if ({o_bus_req, o_bus_err, o_dbg_state} !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_after got %b%b %0d exp 00 0", o_bus_req, o_bus_err, o_dbg_state); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, LD_NONE, ST_SB, 32'h33, 32'h000000A5, 1, 32'h0, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({bw, bm} !== {32'hA5A5A5A5, 4'b1000}) begin tests_failed++; $display("FAIL b2b_sb got %h %b exp a5a5a5a5 1000", bw, bm); end
    cyc();
    run_access(1'b0, LD_LBU, ST_NONE, 32'h33, 32'h0, 3, 32'hA5000000, ld, sn, rn, dn, er, ba, bw, bm, we);
    tests_run++; if ({ld, sn} !== {32'h000000A5, 32'd4}) begin tests_failed++; $display("FAIL b2b_lbu got %h %0d exp 000000a5 4", ld, sn); end
    cyc();
  endtask

  initial begin
    set_idle();
    i_rst_n = 1'b0;
    test_reset();
    test_lw_wait();
    test_sub_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_stray_ack();
    test_reset_mid_req();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have these ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_lsu_addr  in  32  effective address from the ALU.
- i_st_data  in  32  store data (rs2).
- i_ld_sel  in  3  load type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5-7 none.
- i_st_sel  in  2  store type: 0 SB, 1 SH, 2 SW, 3 none.
- i_mem_wren  in  1  store request.
- o_ld_data  out  32  extended load result.
- o_stall  out  1  hold PC/regfile.
- o_misaligned  out  1  misaligned-access pulse.
- o_bus_err  out  1  timeout pulse.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  bus write.
- o_bus_addr  out  32  word-aligned address.
- o_bus_wdata  out  32  write data.
- o_bus_bmask  out  4  byte enables.
- i_bus_ack  in  1  bus acknowledge.
- i_bus_rdata  in  32  read data.
REQ-002 SHALL use parameter TIMEOUT, default 255: maximum REQ cycles before abort.

Function
REQ-003 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE.
REQ-004 Access definition:
- store: i_mem_wren=1 and i_st_sel!=3.
- load: i_ld_sel<=4 and not a store.
- Store has priority when both are presented.
REQ-005 Misaligned:
- LW/SW with addr[1:0]!=0.
- LH/LHU/SH with addr[0]=1.
REQ-006 IDLE with a valid aligned access:
- o_stall=1 combinationally in the same cycle.
- Latch addr, data, type and we.
- Next state REQ.
REQ-007 IDLE with a misaligned access:
- o_misaligned=1 for that cycle.
- No bus request, o_stall=0, o_ld_data=0, stay IDLE.
REQ-008 REQ behaviour:
- o_bus_req=1 and o_stall=1.
- o_bus_addr/we/wdata/bmask held stable from latched values until ack.
REQ-009 On i_bus_ack=1 in REQ:
- Capture i_bus_rdata.
- Next state DONE; o_bus_req deasserts next cycle.
REQ-010 Ack outside REQ SHALL be ignored.
REQ-011 Timeout:
- Cycle counter counts REQ cycles.
- If no ack after TIMEOUT cycles: o_bus_err=1 for one cycle, captured data=0, next state DONE.
- Counter clears on REQ entry.
REQ-012 DONE:
- o_stall=0 and o_ld_data valid for exactly one cycle.
- Next state IDLE unconditionally, so the same instruction never re-issues.
- Load-to-use latency = 3 cycles when ack arrives in the first REQ cycle.
REQ-013 Store encoding (lane = addr[1:0]):
- SB: byte replicated to all 4 lanes, bmask = 1<<lane.
- SH: halfword replicated, bmask 0011 (addr[1]=0) or 1100 (addr[1]=1).
- SW: bmask 1111.
- o_bus_addr = {addr[31:2],2'b00}.
REQ-014 Loads SHALL use bmask=1111.
REQ-015 Load extraction from captured word by latched lane:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes through.
REQ-016 o_ld_data SHALL be 0 whenever not in DONE, and for stores.

Reset
REQ-017 i_rst_n=0 at a clock edge SHALL force:
- State IDLE, counter 0.
- All latched registers and all outputs 0.
- Effective next cycle, including mid-REQ (request abandoned, no err pulse).

Structure
REQ-018 lsu_pkg SHALL hold:
- State enum.
- ld_sel/st_sel encodings, including LD_NONE=5 and ST_NONE=3.
- Default TIMEOUT.
REQ-019 Sub-module lsu_ld_align SHALL be combinational lane select + extension, instantiated once.

Verification
REQ-020 LW at 0x100, ack after 2 REQ cycles, rdata 0xDEADBEEF:
- o_stall high 3 cycles.
- DONE o_ld_data=0xDEADBEEF.
REQ-021 LB at 0x203, rdata 0x80112233 -> o_ld_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-022 SH at 0x002, st_data 0x0000ABCD -> bus addr 0x000, wdata 0xABCDABCD, bmask 1100, we=1.
REQ-023 LW at 0x101 -> o_misaligned pulse, no o_bus_req, o_stall=0.
REQ-024 LW with ack never asserted, TIMEOUT=4:
- o_bus_err after 4 REQ cycles.
- DONE data=0, then IDLE.
REQ-025 Reset asserted in the second REQ cycle -> next cycle o_bus_req=0, IDLE, o_stall=0.
